fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/ID boundary register. It owns the program counter and issues one instruction-memory request at a time over a level req/ack handshake. It delivers one `{pc, instruction}` pair per accepted response into IF/ID. It honours the hazard-unit stall and the branch/exception redirect, and discards responses to requests that a redirect has made stale.

---
 rtl/fetch_pkg.sv | 37 +++
 rtl/fetch_pc_gen.sv | 69 ++++++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: default bus widths,
// the NOP encoding, the fetch FSM state encoding, the PC increment and the
// select codes that the FSM uses to steer the PC generator.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_SIZE_DEF  = 32;
    localparam int INSTR_SIZE_DEF = 32;
    localparam int PC_INC         = 4;

    // All-zero instruction word is a NOP in this ISA.
    localparam logic [INSTR_SIZE_DEF-1:0] NOP = '0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding for pc
        HOLD  = 2'd1,   // response buffered while IF/ID is stalled
        DROP  = 2'd2    // waiting out a request made stale by a redirect
    } fetch_state_e;

    // Next-value selects for the pc register.
    typedef enum logic [1:0] {
        PC_KEEP  = 2'd0,
        PC_NEXT  = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_e;

    // Next-value selects for the request-address register.
    typedef enum logic [1:0] {
        REQ_KEEP  = 2'd0,
        REQ_NEXT  = 2'd1,   // pc + 4
        REQ_REDIR = 2'd2,   // aligned redirect target
        REQ_PC    = 2'd3    // current pc (end of a stale request)
    } req_sel_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
// Program-counter and request-address registers for the fetch stage, with
// the +4 adder and the redirect mux. The FSM in fetch_stage chooses what
// each register loads next.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pc_sel_i        next-value select for pc
//   req_sel_i       next-value select for req_addr
//   redirect_pc_i   redirect target (low two bits ignored)
//   pc_o            next instruction to deliver
//   req_addr_o      address driven onto the instruction-memory bus
// ---------------------------------------------------------------------------
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                   ADDR_SIZE = ADDR_SIZE_DEF,
    parameter logic [ADDR_SIZE-1:0] RESET_PC  = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  pc_sel_e              pc_sel_i,
    input  req_sel_e             req_sel_i,
    input  logic [ADDR_SIZE-1:0] redirect_pc_i,
    output logic [ADDR_SIZE-1:0] pc_o,
    output logic [ADDR_SIZE-1:0] req_addr_o
);

    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic [ADDR_SIZE-1:0] req_addr_q, req_addr_d;
    logic [ADDR_SIZE-1:0] pc_next;
    logic [ADDR_SIZE-1:0] redir_aligned;

    // Addition wraps naturally at 2^ADDR_SIZE.
    assign pc_next       = pc_q + ADDR_SIZE'(PC_INC);
    assign redir_aligned = {redirect_pc_i[ADDR_SIZE-1:2], 2'b00};

    always_comb begin
        unique case (pc_sel_i)
            PC_NEXT:  pc_d = pc_next;
            PC_REDIR: pc_d = redir_aligned;
            default:  pc_d = pc_q;
        endcase

        unique case (req_sel_i)
            REQ_NEXT:  req_addr_d = pc_next;
            REQ_REDIR: req_addr_d = redir_aligned;
            REQ_PC:    req_addr_d = pc_q;
            default:   req_addr_d = req_addr_q;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign pc_o       = pc_q;
    assign req_addr_o = req_addr_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage feeding the IF/ID register. Issues one
// instruction-memory request at a time over a level req/ack handshake,
// delivers {pc, instruction} pairs combinationally on the ack, buffers a
// response while the pipeline is stalled, and discards responses made stale
// by a branch/exception redirect.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      hazard-unit stall (also stalls IF/ID)
//   redirect, redirect_pc      flush fetch and restart at redirect_pc
//   imem_req, imem_addr        memory request and its address
//   imem_ack, imem_rdata       memory response and instruction word
//   pc_out, instr_out          pair presented to IF/ID (zero when invalid)
//   valid_out                  pair is a real instruction
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                   ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int                   INSTR_SIZE = INSTR_SIZE_DEF,
    parameter logic [ADDR_SIZE-1:0] RESET_PC   = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_SIZE-1:0]  redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_SIZE-1:0]  imem_addr,
    input  logic                  imem_ack,
    input  logic [INSTR_SIZE-1:0] imem_rdata,
    output logic [ADDR_SIZE-1:0]  pc_out,
    output logic [INSTR_SIZE-1:0] instr_out,
    output logic                  valid_out
);

    fetch_state_e          state_q, state_d;
    logic [INSTR_SIZE-1:0] hold_instr_q, hold_instr_d;
    pc_sel_e               pc_sel;
    req_sel_e              req_sel;
    logic [ADDR_SIZE-1:0]  pc;
    logic                  req_raw;
    logic                  valid_raw;
    logic [INSTR_SIZE-1:0] instr_raw;

    fetch_pc_gen #(
        .ADDR_SIZE (ADDR_SIZE),
        .RESET_PC  (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_sel_i      (pc_sel),
        .req_sel_i     (req_sel),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .req_addr_o    (imem_addr)
    );

    // Priority inside every state: redirect, then ack, then stall.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        hold_instr_d = hold_instr_q;
        pc_sel       = PC_KEEP;
        req_sel      = REQ_KEEP;
        req_raw      = 1'b0;
        valid_raw    = 1'b0;
        instr_raw    = imem_rdata;

        unique case (state_q)
            FETCH: begin
                req_raw = 1'b1;
                if (redirect) begin
                    pc_sel = PC_REDIR;
                    if (imem_ack) begin
                        req_sel = REQ_REDIR;
                    end else begin
                        // Address must stay stable until the old request is acked.
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    valid_raw = 1'b1;
                    if (stall) begin
                        // Shown this cycle but IF/ID ignores it; replay from HOLD.
                        hold_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end else begin
                        pc_sel  = PC_NEXT;
                        req_sel = REQ_NEXT;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_sel  = PC_REDIR;
                    req_sel = REQ_REDIR;
                    state_d = FETCH;
                end else begin
                    valid_raw = 1'b1;
                    instr_raw = hold_instr_q;
                    if (!stall) begin
                        pc_sel  = PC_NEXT;
                        req_sel = REQ_NEXT;
                        state_d = FETCH;
                    end
                end
            end

            DROP: begin
                req_raw = 1'b1;
                if (redirect) begin
                    pc_sel = PC_REDIR;
                end
                if (imem_ack) begin
                    // A redirect arriving with the ack already holds the newest target.
                    req_sel = redirect ? REQ_REDIR : REQ_PC;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // NOTE: hold_instr is a single datapath register, so it takes a reset value
    // along with the control state; nothing here is a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            hold_instr_q <= NOP;
        end else begin
            state_q      <= state_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Gating with rst_n keeps the request low and the outputs cleared for as
    // long as reset is held, even though the state already reads FETCH.
    assign imem_req  = rst_n & req_raw;
    assign valid_out = rst_n & valid_raw;
    assign instr_out = valid_out ? instr_raw : NOP;
    assign pc_out    = valid_out ? pc : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural model tracks what the
// stage owes the pipeline (next PC, address on the bus, whether a buffered
// instruction or a stale request is pending) and predicts the outputs for
// every cycle of directed and random stimulus.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: what the stage still owes and where the bus points.
    logic [31:0] m_pc;       // next PC to deliver
    logic [31:0] m_bus;      // address on the memory bus
    logic        m_buffered; // an instruction is parked waiting for the stall to clear
    logic        m_stale;    // the outstanding request belongs to a flushed path
    logic [31:0] m_word;     // the parked instruction

    fetch_stage #(
        .ADDR_SIZE  (32),
        .INSTR_SIZE (32),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ 32'hC001_D00D;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_init();
        m_pc       = RST_PC;
        m_bus      = RST_PC;
        m_buffered = 1'b0;
        m_stale    = 1'b0;
        m_word     = '0;
    endtask

    // Called mid-cycle: asserts reset asynchronously, checks reset outputs
    // (with a spurious ack on the bus), then releases away from the clock edge.
    task automatic do_reset();
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b1;
        #1;
        check("rst_req",   {31'd0, imem_req},  32'd0);
        check("rst_addr",  imem_addr,          RST_PC);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_pc",    pc_out,             32'd0);
        check("rst_instr", instr_out,          32'd0);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        model_init();
    endtask

    // One clock cycle: apply inputs, predict, check at negedge, advance to posedge+1.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic ack, input logic [31:0] data);
        logic [31:0] tgt, e_addr, e_pc, e_instr;
        logic        e_req, e_valid;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = data;

        tgt     = rpc & ~32'd3;
        e_req   = !m_buffered;
        e_addr  = m_bus;
        e_valid = 1'b0;
        e_pc    = '0;
        e_instr = '0;

        if (m_buffered) begin
            if (rd) begin
                m_pc = tgt; m_bus = tgt; m_buffered = 1'b0;
            end else begin
                e_valid = 1'b1; e_pc = m_pc; e_instr = m_word;
                if (!st) begin
                    m_pc = m_pc + 32'd4; m_bus = m_pc; m_buffered = 1'b0;
                end
            end
        end else if (m_stale) begin
            if (rd) m_pc = tgt;
            if (ack) begin
                m_bus = m_pc; m_stale = 1'b0;
            end
        end else if (rd) begin
            m_pc = tgt;
            if (ack) m_bus = tgt;
            else     m_stale = 1'b1;
        end else if (ack) begin
            e_valid = 1'b1; e_pc = m_pc; e_instr = data;
            if (st) begin
                m_word = data; m_buffered = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4; m_bus = m_pc;
            end
        end

        @(negedge clk);
        check("imem_req",  {31'd0, imem_req},  {31'd0, e_req});
        check("imem_addr", imem_addr,          e_addr);
        check("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
        check("pc_out",    pc_out,             e_pc);
        check("instr_out", instr_out,          e_instr);
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch with no stall or redirect.
    task automatic ack_step();
        step(1'b0, 1'b0, 32'd0, 1'b1, mem_word(m_bus));
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'hBAD0_BAD0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Zero-wait memory: 0x1000, 0x1004, 0x1008 back to back.
        check("first_addr", imem_addr, 32'h0000_1000);
        repeat (3) ack_step();
        check("after3_addr", imem_addr, 32'h0000_100C);

        // Three wait cycles per request.
        repeat (3) begin
            repeat (3) idle_step();
            ack_step();
        end

        // Stall for two cycles coinciding with the ack of 0x1004.
        do_reset();
        ack_step();
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        check("hold_instr", instr_out, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("after_hold_addr", imem_addr, 32'h0000_1008);
        ack_step();

        // Redirect to 0x2002 while 0x1008 is pending; stale ack two cycles later.
        do_reset();
        repeat (2) ack_step();
        step(1'b0, 1'b1, 32'h0000_2002, 1'b0, 32'd0);
        idle_step();
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h5A5A_5A5A);
        check("post_drop_addr", imem_addr, 32'h0000_2000);
        ack_step();

        // Redirect to 0x3000 on the same cycle as an ack.
        step(1'b0, 1'b1, 32'h0000_3000, 1'b1, 32'h1111_2222);
        check("redir_ack_addr", imem_addr, 32'h0000_3000);

        // Wrap from 0xFFFF_FFFC to 0.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h3333_4444);
        ack_step();
        ack_step();
        check("wrap_addr", imem_addr, 32'h0000_0004);

        // Redirect while buffered in HOLD.
        step(1'b1, 1'b0, 32'd0, 1'b1, 32'h7777_8888);
        step(1'b1, 1'b1, 32'h0000_4000, 1'b0, 32'd0);
        ack_step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, ($urandom % 8) == 0, $urandom,
                 ($urandom % 2) == 0, mem_word(m_bus) ^ 32'($urandom % 4));
        end

        // Reset in the middle of a wait.
        ack_step();
        idle_step();
        do_reset();
        ack_step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
